// File: rtl/sample_bridge_if.sv
// Handshake bundle between the codec side, the processing pipeline and the sample bridge.
// The bridge connects through the slave modport; the codec/pipeline side uses the master modport.
interface sample_bridge_if #(
  parameter int data_width = 16
);
  logic [data_width-1:0] adc_sample;
  logic                  adc_valid;
  logic [data_width-1:0] pipe_in_sample;
  logic                  pipe_in_valid;
  logic                  pipe_ready;
  logic [data_width-1:0] pipe_out_sample;
  logic [data_width-1:0] dac_sample;
  logic                  dac_valid;
  logic [15:0]           overrun_count;
  logic                  timeout;

  modport master (
    output adc_sample, adc_valid, pipe_ready, pipe_out_sample,
    input  pipe_in_sample, pipe_in_valid, dac_sample, dac_valid, overrun_count, timeout
  );

  modport slave (
    input  adc_sample, adc_valid, pipe_ready, pipe_out_sample,
    output pipe_in_sample, pipe_in_valid, dac_sample, dac_valid, overrun_count, timeout
  );
endinterface

// File: rtl/sample_bridge.sv
// Sample-rate bridge: ADC samples are queued in a small FIFO, handed to the pipeline one at a
// time, and each processed result is strobed out to the DAC.
module sample_bridge #(
  parameter int data_width     = 16,
  parameter int fifo_depth     = 4,
  parameter int timeout_cycles = 4096
) (
  input logic            clk,
  input logic            reset,
  sample_bridge_if.slave bus
);
  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = $clog2(fifo_depth + 1);
  localparam int tmo_w = $clog2(timeout_cycles + 1);
  localparam logic [cnt_w-1:0] fifo_full_c = cnt_w'(fifo_depth);
  localparam logic [tmo_w-1:0] tmo_max_c   = tmo_w'(timeout_cycles);
  localparam logic [tmo_w-1:0] tmo_last_c  = tmo_w'(timeout_cycles - 1);

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_issue  = 2'd1,
    st_settle = 2'd2,
    st_busy   = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [data_width-1:0] fifo_mem_r [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr_r;
  logic [ptr_w-1:0]      rd_ptr_r;
  logic [cnt_w-1:0]      count_r;
  logic                  can_pop_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  dac_load_s;
  logic                  tmo_clr_s;
  logic                  tmo_inc_s;
  logic [data_width-1:0] pipe_in_sample_r;
  logic                  pipe_in_valid_r;
  logic [data_width-1:0] dac_sample_r;
  logic                  dac_valid_r;
  logic [15:0]           overrun_count_r;
  logic                  timeout_r;
  logic [tmo_w-1:0]      tmo_cnt_r;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  assign can_pop_s = (count_r != {cnt_w{1'b0}}) && bus.pipe_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is only dropped without one.
  assign push_s    = bus.adc_valid && ((count_r != fifo_full_c) || pop_s);
  assign drop_s    = bus.adc_valid && (count_r == fifo_full_c) && !pop_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= st_idle;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      st_idle: begin
        if (can_pop_s) state_nxt_s = st_issue;
        else           state_nxt_s = st_idle;
      end
      st_issue:  state_nxt_s = st_settle;
      // ready from the pipeline still reflects the previous sample here, so it is not looked at
      st_settle: state_nxt_s = st_busy;
      st_busy: begin
        if (bus.pipe_ready) state_nxt_s = st_idle;
        else                state_nxt_s = st_busy;
      end
      default:   state_nxt_s = st_idle;
    endcase
  end

  // Per-state control strobes for the FIFO, DAC register and timeout counter
  always_comb begin
    pop_s      = 1'b0;
    dac_load_s = 1'b0;
    tmo_clr_s  = 1'b0;
    tmo_inc_s  = 1'b0;
    case (state_r)
      st_idle:   pop_s = can_pop_s;
      st_issue:  pop_s = 1'b0;
      st_settle: tmo_clr_s = 1'b1;
      st_busy: begin
        if (bus.pipe_ready) dac_load_s = 1'b1;
        else                tmo_inc_s  = 1'b1;
      end
      default:   pop_s = 1'b0;
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < fifo_depth; i++) fifo_mem_r[i] <= {data_width{1'b0}};
      wr_ptr_r <= {ptr_w{1'b0}};
      rd_ptr_r <= {ptr_w{1'b0}};
      count_r  <= {cnt_w{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.adc_sample;
        wr_ptr_r             <= wr_ptr_r + ptr_w'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered pipeline/DAC outputs, overrun counter and stall watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_in_sample_r <= {data_width{1'b0}};
      pipe_in_valid_r  <= 1'b0;
      dac_sample_r     <= {data_width{1'b0}};
      dac_valid_r      <= 1'b0;
      overrun_count_r  <= 16'd0;
      timeout_r        <= 1'b0;
      tmo_cnt_r        <= {tmo_w{1'b0}};
    end else begin
      // pipe_in_sample only moves on issue; the pipeline reads it combinationally until done
      if (pop_s) pipe_in_sample_r <= fifo_mem_r[rd_ptr_r];
      pipe_in_valid_r <= pop_s;
      if (dac_load_s) dac_sample_r <= bus.pipe_out_sample;
      dac_valid_r <= dac_load_s;
      if (drop_s) overrun_count_r <= sat_inc16(overrun_count_r);
      if (tmo_clr_s) begin
        tmo_cnt_r <= {tmo_w{1'b0}};
      end else if (tmo_inc_s && (tmo_cnt_r != tmo_max_c)) begin
        tmo_cnt_r <= tmo_cnt_r + tmo_w'(1);
      end
      if (tmo_inc_s && (tmo_cnt_r == tmo_last_c)) timeout_r <= 1'b1;
    end
  end

  assign bus.pipe_in_sample = pipe_in_sample_r;
  assign bus.pipe_in_valid  = pipe_in_valid_r;
  assign bus.dac_sample     = dac_sample_r;
  assign bus.dac_valid      = dac_valid_r;
  assign bus.overrun_count  = overrun_count_r;
  assign bus.timeout        = timeout_r;
endmodule

// File: tb/tb_sample_bridge.sv
// Directed bench for sample_bridge: a table of single-sample transactions followed by
// hand-written burst, overrun, full push+pop, timeout and mid-flight reset sequences.
module tb_sample_bridge;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sample_bridge_if #(.data_width(16)) bus ();

  sample_bridge #(
    .data_width(16),
    .fifo_depth(4),
    .timeout_cycles(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipeline model: drops ready on in_valid, raises it proc_cycles later unless held
  int proc_cycles = 5;
  int model_mode  = 0;
  bit hold_busy   = 1'b0;
  bit ready_low   = 1'b0;
  bit model_clear = 1'b1;
  int mcnt        = 0;
  always @(negedge clk) begin
    if (model_clear) begin
      bus.pipe_ready      = 1'b1;
      bus.pipe_out_sample = 16'h0000;
      mcnt                = 0;
    end else if (ready_low) begin
      bus.pipe_ready = 1'b0;
    end else if (bus.pipe_in_valid) begin
      bus.pipe_ready = 1'b0;
      mcnt           = proc_cycles;
      if (model_mode == 0) bus.pipe_out_sample = 16'($signed(bus.pipe_in_sample) >>> 3);
      else                 bus.pipe_out_sample = ~bus.pipe_in_sample;
    end else if (!bus.pipe_ready) begin
      if (mcnt > 0) mcnt = mcnt - 1;
      if (mcnt == 0 && !hold_busy) bus.pipe_ready = 1'b1;
    end
  end

  // Monitor: logs issues and DAC strobes, flags multi-cycle pulses and unstable pipe_in_sample
  logic [15:0] issue_smp_q[$];
  int          issue_cyc_q[$];
  logic [15:0] dac_smp_q[$];
  int          dac_cyc_q[$];
  int          pulse_err = 0;
  int          stab_err  = 0;
  logic        prev_piv  = 1'b0;
  logic        prev_dv   = 1'b0;
  logic        prev_rst  = 1'b1;
  logic [15:0] prev_pis  = 16'h0000;
  always @(negedge clk) begin
    if (bus.pipe_in_valid) begin
      issue_smp_q.push_back(bus.pipe_in_sample);
      issue_cyc_q.push_back(cyc);
    end
    if (bus.dac_valid) begin
      dac_smp_q.push_back(bus.dac_sample);
      dac_cyc_q.push_back(cyc);
    end
    if (bus.pipe_in_valid && prev_piv) pulse_err++;
    if (bus.dac_valid && prev_dv) pulse_err++;
    if (!bus.pipe_in_valid && !reset && !prev_rst && bus.pipe_in_sample !== prev_pis) stab_err++;
    prev_piv = bus.pipe_in_valid;
    prev_dv  = bus.dac_valid;
    prev_rst = reset;
    prev_pis = bus.pipe_in_sample;
  end

  typedef struct {
    logic [15:0] sample;
    int          proc;
    int          mode;
    logic [15:0] exp_out;
    int          exp_lat;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] issue_at(input int k);
    if (k < issue_smp_q.size()) return issue_smp_q[k];
    else return 16'hDEAD;
  endfunction

  function automatic logic [15:0] dac_at(input int k);
    if (k < dac_smp_q.size()) return dac_smp_q[k];
    else return 16'hDEAD;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    issue_smp_q.delete();
    issue_cyc_q.delete();
    dac_smp_q.delete();
    dac_cyc_q.delete();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    model_clear   = 1'b1;
    hold_busy     = 1'b0;
    ready_low     = 1'b0;
    bus.adc_valid = 1'b0;
    steps(2);
    reset       = 1'b0;
    model_clear = 1'b0;
    clear_logs();
    step();
  endtask

  task automatic push(input logic [15:0] s);
    bus.adc_valid  = 1'b1;
    bus.adc_sample = s;
    step();
    bus.adc_valid = 1'b0;
  endtask

  task automatic wait_dac(input int n, input int budget, input string name);
    int k = 0;
    while (dac_smp_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check({name, "_dac_count"}, dac_smp_q.size(), n);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_pipe_in_sample"}, bus.pipe_in_sample, 16'h0000);
    check({name, "_pipe_in_valid"},  bus.pipe_in_valid,  1'b0);
    check({name, "_dac_sample"},     bus.dac_sample,     16'h0000);
    check({name, "_dac_valid"},      bus.dac_valid,      1'b0);
    check({name, "_overrun"},        bus.overrun_count,  16'h0000);
    check({name, "_timeout"},        bus.timeout,        1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int i0;
    logic [15:0] exp_issue[$];
    logic [15:0] exp_dac[$];

    vecs[0] = '{16'h1234, 5, 0, 16'h0246, 6};
    vecs[1] = '{16'h8000, 2, 0, 16'hF000, 3};
    vecs[2] = '{16'h7FFF, 9, 0, 16'h0FFF, 10};
    vecs[3] = '{16'hFFF8, 5, 0, 16'hFFFF, 6};
    vecs[4] = '{16'hA5A5, 2, 1, 16'h5A5A, 3};
    vecs[5] = '{16'h0000, 2, 1, 16'hFFFF, 3};

    bus.adc_sample = 16'h0000;
    bus.adc_valid  = 1'b0;
    do_reset();
    check_outputs_zero("reset");

    // Single transactions: issue latency, bit-exact data, ready-to-DAC latency
    for (int v = 0; v < 6; v++) begin
      proc_cycles = vecs[v].proc;
      model_mode  = vecs[v].mode;
      t = cyc;
      push(vecs[v].sample);
      wait_dac(v + 1, 40, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_issue_count", v), issue_smp_q.size(), v + 1);
      if (issue_smp_q.size() > v && dac_smp_q.size() > v) begin
        check($sformatf("vec%0d_issue_lat", v), issue_cyc_q[v] - t, 2);
        check($sformatf("vec%0d_in_sample", v), issue_smp_q[v], vecs[v].sample);
        check($sformatf("vec%0d_dac_sample", v), dac_smp_q[v], vecs[v].exp_out);
        check($sformatf("vec%0d_dac_lat", v), dac_cyc_q[v] - issue_cyc_q[v], vecs[v].exp_lat);
      end
      step();
    end

    // Burst of four with a slow pipeline
    do_reset();
    proc_cycles = 20;
    model_mode  = 1;
    for (int k = 1; k <= 4; k++) push(16'(k));
    wait_dac(4, 200, "burst");
    exp_dac = '{16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("burst_issue%0d", k), issue_at(k), 16'(k + 1));
      check($sformatf("burst_dac%0d", k), dac_at(k), exp_dac[k]);
    end
    check("burst_overrun", bus.overrun_count, 16'd0);

    // Overrun: seven samples while the pipeline is held busy
    do_reset();
    proc_cycles = 3;
    model_mode  = 1;
    hold_busy   = 1'b1;
    for (int k = 0; k < 7; k++) push(16'h0011 + 16'(k));
    step();
    check("overrun_count", bus.overrun_count, 16'd2);
    check("overrun_issued_while_busy", issue_smp_q.size(), 1);
    hold_busy = 1'b0;
    wait_dac(5, 100, "overrun");
    exp_issue = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
    exp_dac   = '{16'hFFEE, 16'hFFED, 16'hFFEC, 16'hFFEB, 16'hFFEA};
    for (int k = 0; k < 5; k++) begin
      check($sformatf("overrun_issue%0d", k), issue_at(k), exp_issue[k]);
      check($sformatf("overrun_dac%0d", k), dac_at(k), exp_dac[k]);
    end
    check("overrun_total_issues", issue_smp_q.size(), 5);

    // Full FIFO in IDLE: ready rises in the same cycle as adc_valid
    do_reset();
    proc_cycles = 2;
    model_mode  = 1;
    ready_low   = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) push(16'h0A00 + 16'(k));
    push(16'h0AFF);
    check("full_drop_overrun", bus.overrun_count, 16'd1);
    check("full_no_issue", issue_smp_q.size(), 0);
    ready_low = 1'b0;
    t = cyc;
    push(16'h0A05);
    step();
    check("full_pushpop_overrun", bus.overrun_count, 16'd1);
    wait_dac(5, 100, "full");
    check("full_total_issues", issue_smp_q.size(), 5);
    if (issue_cyc_q.size() > 0) check("full_first_issue_lat", issue_cyc_q[0] - t, 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("full_issue%0d", k), issue_at(k), 16'h0A01 + 16'(k));
    end

    // Timeout: ready held low in BUSY
    do_reset();
    proc_cycles = 3;
    model_mode  = 1;
    hold_busy   = 1'b1;
    push(16'h4321);
    steps(2);
    check("tmo_issued", issue_smp_q.size(), 1);
    i0 = (issue_cyc_q.size() > 0) ? issue_cyc_q[0] : cyc;
    while (cyc < i0 + 9) step();
    check("tmo_before_limit", bus.timeout, 1'b0);
    step();
    check("tmo_at_limit", bus.timeout, 1'b1);
    steps(5);
    check("tmo_sticky_busy", bus.timeout, 1'b1);
    check("tmo_no_dac", dac_smp_q.size(), 0);
    hold_busy = 1'b0;
    wait_dac(1, 20, "tmo");
    check("tmo_dac_sample", dac_at(0), 16'hBCDE);
    check("tmo_sticky_after", bus.timeout, 1'b1);

    // Reset while BUSY with queued samples and a recorded overrun
    do_reset();
    proc_cycles = 3;
    model_mode  = 1;
    hold_busy   = 1'b1;
    for (int k = 1; k <= 6; k++) push(16'h0600 + 16'(k));
    steps(3);
    check("rst_pre_overrun", bus.overrun_count, 16'd1);
    check("rst_pre_issues", issue_smp_q.size(), 1);
    reset       = 1'b1;
    model_clear = 1'b1;
    hold_busy   = 1'b0;
    step();
    check_outputs_zero("midrst");
    reset       = 1'b0;
    model_clear = 1'b0;
    clear_logs();
    steps(20);
    check("rst_no_issue", issue_smp_q.size(), 0);
    check("rst_no_dac", dac_smp_q.size(), 0);
    push(16'h0777);
    wait_dac(1, 20, "rst_new");
    check("rst_new_issue", issue_at(0), 16'h0777);
    check("rst_new_dac", dac_at(0), 16'hF888);

    check("pulse_width_errors", pulse_err, 0);
    check("in_sample_stability_errors", stab_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
